alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//  Issue/sequencing controller between decode and the ALU. Accepts one instruction
//  (op, rs1, rs2/imm, rd) via valid/ready and presents operands serially on the
//  ALU's shared rs_data bus (sel=0 rs1, sel=1 rs2). It then waits for alu_valid_out/op_done
//  and hands the result to writeback via valid/ready. A hung ALU is flagged by a timeout.
// PARAMETERS
//  BUS      32  data width of operands, immediate and result
//  OPCODE   11  ALU opcode width
//  RD_W      5  destination register index width
//  TIMEOUT  16  max WAIT cycles for alu_valid_out before error (>=2)
// PORTS
//  clk               in   1       clock; all logic on posedge
//  rst               in   1       synchronous reset, active-high
//  iss_valid         in   1       decode has an instruction
//  iss_ready         out  1       controller accepts instruction this cycle
//  iss_op_code       in   OPCODE  ALU opcode
//  iss_rs1           in   BUS     rs1 value
//  iss_rs2           in   BUS     rs2 value
//  iss_imm           in   BUS     immediate value
//  iss_use_imm       in   1       1: I-type, rs2 phase skipped
//  iss_rd            in   RD_W    destination register
//  alu_op_code       out  OPCODE  opcode to ALU
//  alu_imme_value    out  BUS     immediate to ALU
//  alu_rs_data       out  BUS     serial operand bus
//  alu_rs_data_sel   out  1       0 = rs1, 1 = rs2
//  alu_rs_data_valid out  1       operand on alu_rs_data valid this cycle
//  alu_out           in   BUS     ALU result
//  alu_valid_out     in   1       alu_out valid this cycle
//  alu_op_done       in   1       ALU finished current instruction
//  wb_valid          out  1       result available
//  wb_ready          in   1       writeback consumes result
//  wb_data           out  BUS     result (0 on error)
//  wb_rd             out  RD_W    destination register of result
//  wb_err            out  1       result produced by timeout
//  busy              out  1       state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 except iss_ready=1; timeout counter 0.
//  - States: IDLE, SEND_RS1, SEND_RS2, WAIT, DONE.
//  - iss_ready = (state==IDLE) && (!wb_valid || wb_ready), combinational.
//  - IDLE: iss_valid&&iss_ready latches op/rs1/rs2/imm/use_imm/rd -> SEND_RS1.
//  - alu_op_code and alu_imme_value are registered from latch; held stable SEND_RS1..DONE.
//  - SEND_RS1 (1 cycle): rs_data=rs1, sel=0, valid=1 -> SEND_RS2 (use_imm=0) or WAIT.
//  - SEND_RS2 (1 cycle): rs_data=rs2, sel=1, valid=1 -> WAIT.
//  - rs_data_valid=0 in all other states; rs_data/sel then hold last value.
//  - WAIT: cnt increments each cycle from 0.
//    - alu_valid_out=1: capture alu_out -> wb_data, rd -> wb_rd, wb_err=0, wb_valid=1.
//      Goes to IDLE if alu_op_done same cycle, else DONE.
//    - else cnt==TIMEOUT-1: wb_data=0, wb_err=1, wb_valid=1 -> IDLE.
//  - DONE: wait for alu_op_done -> IDLE. No timeout in DONE.
//  - alu_valid_out/alu_op_done outside WAIT/DONE are ignored.
//  - wb_valid held with data stable until wb_ready; cleared on wb_valid&&wb_ready.
//    - Result capture never occurs while wb_valid=1; iss_ready gating guarantees this.
//  - Back-to-back: wb handshake and new issue may occur in the same IDLE cycle.
//  - Latency: issue accepted cycle T -> rs1 at T+1, rs2 at T+2 (R-type).
//    ALU valid at cycle V (>= first WAIT cycle) -> wb_valid at V+1.
//  - rst mid-operation: abort immediately to reset values; pending wb result dropped.
// TESTING
//  - R-type: op=ADD, rs1=5, rs2=7, ALU valid+done 2 cyc after rs2 -> rs phases sel 0/1,
//    wb_data=12, wb_rd=iss_rd, wb_err=0.
//  - I-type: use_imm=1, rs1=0x10, imm=0x3 -> only sel=0 phase seen, imme_value=3 held.
//  - Writeback stall: wb_ready=0 for 5 cycles with iss_valid=1 -> iss_ready=0 and
//    wb_data stable; wb_ready=1 -> same-cycle accept of next instruction.
//  - Split done: alu_valid_out at WAIT cycle 1, op_done 3 cycles later -> wb_valid early,
//    busy until op_done, iss_ready=0 until IDLE.
//  - Timeout: ALU never responds, TIMEOUT=16 -> wb_valid with wb_err=1, wb_data=0
//    exactly 16 WAIT cycles after entry.
//  - Reset in WAIT and with wb_valid pending -> next cycle all outputs at reset values;
//    spurious alu_valid_out in IDLE ignored.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing controller: takes one instruction from decode, serialises rs1/rs2
// onto the ALU operand bus, waits for the ALU result (with timeout) and hands it to writeback.
module alu_issue_ctrl #(
   parameter int BUS     = 32,
   parameter int OPCODE  = 11,
   parameter int RD_W    = 5,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              iss_valid,
   output logic              iss_ready,
   input  logic [OPCODE-1:0] iss_op_code,
   input  logic [BUS-1:0]    iss_rs1,
   input  logic [BUS-1:0]    iss_rs2,
   input  logic [BUS-1:0]    iss_imm,
   input  logic              iss_use_imm,
   input  logic [RD_W-1:0]   iss_rd,
   output logic [OPCODE-1:0] alu_op_code,
   output logic [BUS-1:0]    alu_imme_value,
   output logic [BUS-1:0]    alu_rs_data,
   output logic              alu_rs_data_sel,
   output logic              alu_rs_data_valid,
   input  logic [BUS-1:0]    alu_out,
   input  logic              alu_valid_out,
   input  logic              alu_op_done,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [BUS-1:0]    wb_data,
   output logic [RD_W-1:0]   wb_rd,
   output logic              wb_err,
   output logic              busy
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SEND_RS1 = 3'd1,
      ST_SEND_RS2 = 3'd2,
      ST_WAIT     = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [BUS-1:0]    rs2_q;
   logic              use_imm_q;
   logic [RD_W-1:0]   rd_q;
   logic [OPCODE-1:0] op_code_q;
   logic [BUS-1:0]    imm_q;
   logic [BUS-1:0]    rs_data_q;
   logic              rs_sel_q;
   logic              rs_vld_q;
   logic              wb_valid_q;
   logic [BUS-1:0]    wb_data_q;
   logic [RD_W-1:0]   wb_rd_q;
   logic              wb_err_q;

   // A new issue is only taken once the writeback slot is free (or being freed this cycle),
   // so a result capture can never overwrite a pending result.
   assign iss_ready         = (state_q == ST_IDLE) && (!wb_valid_q || wb_ready);
   assign busy              = (state_q != ST_IDLE);
   assign alu_op_code       = op_code_q;
   assign alu_imme_value    = imm_q;
   assign alu_rs_data       = rs_data_q;
   assign alu_rs_data_sel   = rs_sel_q;
   assign alu_rs_data_valid = rs_vld_q;
   assign wb_valid          = wb_valid_q;
   assign wb_data           = wb_data_q;
   assign wb_rd             = wb_rd_q;
   assign wb_err            = wb_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         rs2_q      <= '0;
         use_imm_q  <= 1'b0;
         rd_q       <= '0;
         op_code_q  <= '0;
         imm_q      <= '0;
         rs_data_q  <= '0;
         rs_sel_q   <= 1'b0;
         rs_vld_q   <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         wb_rd_q    <= '0;
         wb_err_q   <= 1'b0;
      end else begin
         if (wb_valid_q && wb_ready) begin
            wb_valid_q <= 1'b0;
         end
         case (state_q)
            ST_IDLE: begin
               if (iss_valid && iss_ready) begin
                  rs2_q     <= iss_rs2;
                  use_imm_q <= iss_use_imm;
                  rd_q      <= iss_rd;
                  op_code_q <= iss_op_code;
                  imm_q     <= iss_imm;
                  rs_data_q <= iss_rs1;
                  rs_sel_q  <= 1'b0;
                  rs_vld_q  <= 1'b1;
                  state_q   <= ST_SEND_RS1;
               end
            end
            ST_SEND_RS1: begin
               if (!use_imm_q) begin
                  rs_data_q <= rs2_q;
                  rs_sel_q  <= 1'b1;
                  rs_vld_q  <= 1'b1;
                  state_q   <= ST_SEND_RS2;
               end else begin
                  rs_vld_q  <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= ST_WAIT;
               end
            end
            ST_SEND_RS2: begin
               rs_vld_q <= 1'b0;
               cnt_q    <= '0;
               state_q  <= ST_WAIT;
            end
            ST_WAIT: begin
               if (alu_valid_out) begin
                  wb_data_q  <= alu_out;
                  wb_rd_q    <= rd_q;
                  wb_err_q   <= 1'b0;
                  wb_valid_q <= 1'b1;
                  state_q    <= alu_op_done ? ST_IDLE : ST_DONE;
               end else if (cnt_q == CNT_LAST) begin
                  wb_data_q  <= '0;
                  wb_rd_q    <= rd_q;
                  wb_err_q   <= 1'b1;
                  wb_valid_q <= 1'b1;
                  state_q    <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_DONE: begin
               if (alu_op_done) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
